// File: rtl/charlieplex_pkg.sv
// Shared definitions for the charlieplexed key scanner: sizing helpers and FSM states.
package charlieplex_pkg;

  typedef enum logic [2:0] {IDLE, SETTLE, SAMPLE, EMIT, NEXT} state_e;

  function automatic int key_count(input int pins);
    return pins * (pins - 1);
  endfunction

  function automatic int index_bits(input int pins);
    return $clog2(pins * (pins - 1));
  endfunction

  function automatic int pin_bits(input int pins);
    return $clog2(pins);
  endfunction

endpackage

// File: rtl/charlieplex_scanner_if.sv
// Pin bus plus key-event handshake between the scanner (master) and its consumer (slave).
interface charlieplex_scanner_if #(parameter int PINCOUNT = 4);
  localparam int KEYCOUNT  = charlieplex_pkg::key_count(PINCOUNT);
  localparam int INDEXBITS = charlieplex_pkg::index_bits(PINCOUNT);

  logic                 enable;
  logic [PINCOUNT-1:0]  pin_out_en;
  logic [PINCOUNT-1:0]  pin_out_value;
  logic [PINCOUNT-1:0]  pin_in;
  logic                 ev_valid;
  logic                 ev_ready;
  logic [INDEXBITS-1:0] ev_key;
  logic                 ev_pressed;
  logic [KEYCOUNT-1:0]  keys;

  modport master (input  enable, pin_in, ev_ready,
                  output pin_out_en, pin_out_value, ev_valid, ev_key, ev_pressed, keys);
  modport slave  (output enable, pin_in, ev_ready,
                  input  pin_out_en, pin_out_value, ev_valid, ev_key, ev_pressed, keys);
endinterface

// File: rtl/charlieplex_scanner_keyindex.sv
// Maps a (driven pin, sense pin) pair to its flat key index.
module charlieplex_keyindex
  import charlieplex_pkg::*;
#(
  parameter  int PINCOUNT = 4,
  localparam int DW = pin_bits(PINCOUNT),
  localparam int IW = index_bits(PINCOUNT)
) (
  input  logic [DW-1:0] d,
  input  logic [DW-1:0] s,
  output logic [IW-1:0] k
);
  logic [IW-1:0] col;

  // The driven pin is skipped in its own row, so senses above it shift down by one.
  always_comb begin
    col = (s < d) ? IW'(s) : IW'(s) - IW'(1);
    k   = IW'(d) * IW'(PINCOUNT - 1) + col;
  end
endmodule

// File: rtl/charlieplex_scanner.sv
// Row-by-row charlieplex scanner with two-scan debounce and a ready/valid change-event stream.
module charlieplex_scanner
  import charlieplex_pkg::*;
#(
  parameter int PINCOUNT      = 4,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  charlieplex_scanner_if.master io
);
  localparam int DW = pin_bits(PINCOUNT);
  localparam int IW = index_bits(PINCOUNT);
  localparam int RW = PINCOUNT - 1;

  // Row-major key matrix: bit [d][j] sits at flat index d*RW + j.
  typedef logic [PINCOUNT-1:0][RW-1:0] matrix_t;

  state_e        state_q, state_d;
  logic [DW-1:0] d_q, d_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [RW-1:0] pend_q, pend_d;
  matrix_t       keys_q, keys_d, raw_prev_q, raw_prev_d;

  logic [RW-1:0] row_raw, chg, pend_clr;
  logic [DW-1:0] sel_j, sel_s;
  logic [IW-1:0] key_idx;
  logic          ev_valid;

  always_comb begin
    row_raw = '0;
    for (int j = 0; j < RW; j++)
      row_raw[j] = ~io.pin_in[(DW'(j) < d_q) ? DW'(j) : DW'(j + 1)];
    // Debounce: flip only when two consecutive scans agree on a new level.
    chg = (row_raw ~^ raw_prev_q[d_q]) & (row_raw ^ keys_q[d_q]);
    sel_j = '0;
    for (int j = RW - 1; j >= 0; j--)
      if (pend_q[j]) sel_j = DW'(j);
    sel_s    = (sel_j < d_q) ? sel_j : sel_j + DW'(1);
    pend_clr = pend_q & ~(RW'(1) << sel_j);
  end

  charlieplex_keyindex #(.PINCOUNT(PINCOUNT)) u_keyindex (
    .d (d_q),
    .s (sel_s),
    .k (key_idx)
  );

  always_comb begin
    state_d    = state_q;
    d_d        = d_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    keys_d     = keys_q;
    raw_prev_d = raw_prev_q;
    case (state_q)
      IDLE: if (io.enable) begin
        state_d = SETTLE;
        cnt_d   = '0;
      end
      SETTLE: begin
        if (cnt_q == 8'(SETTLE_CYCLES - 1)) state_d = SAMPLE;
        else                                cnt_d   = cnt_q + 8'd1;
      end
      SAMPLE: begin
        raw_prev_d[d_q] = row_raw;
        pend_d          = chg;
        state_d         = (|chg) ? EMIT : NEXT;
      end
      EMIT: if (io.ev_ready) begin
        keys_d[d_q][sel_j] = ~keys_q[d_q][sel_j];
        pend_d             = pend_clr;
        if (pend_clr == '0) state_d = NEXT;
      end
      NEXT: begin
        d_d     = (d_q == DW'(PINCOUNT - 1)) ? '0 : d_q + DW'(1);
        cnt_d   = '0;
        state_d = io.enable ? SETTLE : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      d_q        <= '0;
      cnt_q      <= '0;
      pend_q     <= '0;
      keys_q     <= '0;
      raw_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      d_q        <= d_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      keys_q     <= keys_d;
      raw_prev_q <= raw_prev_d;
    end
  end

  // Only ever pull one pin low; everything else floats on the external pull-ups.
  assign ev_valid         = (state_q == EMIT);
  assign io.pin_out_en    = (state_q == IDLE) ? '0 : (PINCOUNT'(1) << d_q);
  assign io.pin_out_value = '0;
  assign io.ev_valid      = ev_valid;
  assign io.ev_key        = ev_valid ? key_idx : '0;
  assign io.ev_pressed    = ev_valid & ~keys_q[d_q][sel_j];
  assign io.keys          = keys_q;

endmodule

// File: tb/tb_charlieplex_scanner.sv
// Randomised bench for charlieplex_scanner with a per-row debounce model and directed corner cases.
module tb_charlieplex_scanner;
  import charlieplex_pkg::*;

  localparam int P  = 4;
  localparam int S  = 3;
  localparam int KC = key_count(P);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  charlieplex_scanner_if #(.PINCOUNT(P)) io();
  charlieplex_scanner #(.PINCOUNT(P), .SETTLE_CYCLES(S)) dut (.clk(clk), .rst(rst), .io(io));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Physical key matrix; press_pend is latched into press at each row-0 start.
  logic [KC-1:0] press      = '0;
  logic [KC-1:0] press_pend = '0;

  always_comb begin
    io.pin_in = '1;
    for (int d = 0; d < P; d++)
      if (io.pin_out_en[d]) begin
        io.pin_in[d] = 1'b0;
        for (int j = 0; j < P - 1; j++)
          if (press[d*(P-1) + j]) io.pin_in[(j < d) ? j : j + 1] = 1'b0;
      end
  end

  typedef struct { int k; bit p; } ev_t;
  ev_t           evq[$];
  ev_t           ev;
  logic [KC-1:0] m_keys, m_prev;
  logic [P-1:0]  last_en;
  int            exp_d, m_d, m_k;
  int            n_scans = 0, n_acc = 0, bad_onehot = 0, bad_val = 0;
  bit            last_p;

  always @(negedge clk) begin
    if (rst) begin
      m_keys = '0; m_prev = '0; evq.delete(); exp_d = 0; last_en = '0;
    end else begin
      if (io.pin_out_en != '0 && io.pin_out_en != last_en) begin
        for (int i = 0; i < P; i++) if (io.pin_out_en[i]) m_d = i;
        chk("row_order", m_d, exp_d);
        chk("row_keys", io.keys, m_keys);
        chk("row_drained", evq.size(), 0);
        exp_d = (m_d + 1) % P;
        if (m_d == 0) begin press = press_pend; n_scans++; end
        for (int j = 0; j < P - 1; j++) begin
          m_k = m_d*(P-1) + j;
          if (press[m_k] == m_prev[m_k] && press[m_k] != m_keys[m_k]) begin
            evq.push_back('{m_k, press[m_k]});
            m_keys[m_k] = press[m_k];
          end
          m_prev[m_k] = press[m_k];
        end
      end
      last_en = io.pin_out_en;
      if ($countones(io.pin_out_en) > 1) bad_onehot++;
      if (io.pin_out_value != '0) bad_val++;
      if (io.ev_valid && io.ev_ready) begin
        if (evq.size() == 0) chk("ev_spurious", io.ev_valid, 0);
        else begin
          ev = evq.pop_front();
          chk("ev_key", io.ev_key, ev.k);
          chk("ev_pressed", io.ev_pressed, ev.p);
          n_acc++;
          last_p = io.ev_pressed;
        end
      end
    end
  end

  task automatic wait_scans(input int n);
    int t0 = n_scans;
    int c  = 0;
    while (n_scans < t0 + n && c < 5000) begin @(negedge clk); c++; end
    if (c >= 5000) chk("scan_timeout", n_scans, t0 + n);
  endtask

  task automatic wait_en(input logic [P-1:0] tgt);
    int c = 0;
    while (io.pin_out_en != tgt && c < 200) begin @(negedge clk); c++; end
    if (c >= 200) chk("en_timeout", io.pin_out_en, tgt);
  endtask

  task automatic wait_valid();
    int c = 0;
    while (!io.ev_valid && c < 500) begin @(negedge clk); c++; end
    if (c >= 500) chk("valid_timeout", io.ev_valid, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a0, cnt;
    logic [P-1:0] cur;
    bit saw_ev;
    io.enable = 1'b0; io.ev_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", io.ev_valid, 0);
    chk("rst_keys", io.keys, 0);
    chk("rst_en", io.pin_out_en, 0);
    chk("rst_key", io.ev_key, 0);
    chk("rst_pressed", io.ev_pressed, 0);
    chk("rst_value", io.pin_out_value, 0);
    rst = 1'b0;

    // Idle matrix: each pin held SETTLE+2 clocks in order, no events.
    @(posedge clk); #1 io.enable = 1'b1;
    wait_en(4'b0001);
    saw_ev = 0;
    for (int r = 0; r < 2*P; r++) begin
      cur = io.pin_out_en;
      cnt = 0;
      while (io.pin_out_en == cur && cnt < 50) begin
        if (io.ev_valid) saw_ev = 1;
        cnt++;
        @(negedge clk);
      end
      chk("row_hold", cnt, S + 2);
      chk("row_en", cur, 4'b0001 << (r % P));
    end
    chk("idle_no_ev", saw_ev, 0);

    // Single-scan glitch on key 5 is filtered.
    a0 = n_acc;
    press_pend[5] = 1'b1; wait_scans(1);
    press_pend[5] = 1'b0; wait_scans(3);
    chk("glitch_events", n_acc - a0, 0);
    chk("glitch_keys", io.keys[5], 0);

    // Key 5 held three scans, then released.
    a0 = n_acc;
    press_pend[5] = 1'b1; wait_scans(3);
    press_pend[5] = 1'b0; wait_scans(1);
    chk("k5_press_events", n_acc - a0, 1);
    chk("k5_press_pol", last_p, 1);
    chk("k5_keys_set", io.keys[5], 1);
    wait_scans(2);
    chk("k5_rel_events", n_acc - a0, 2);
    chk("k5_rel_pol", last_p, 0);
    chk("k5_keys_clr", io.keys[5], 0);

    // Keys 3 and 5 together under backpressure.
    @(posedge clk); #1 io.ev_ready = 1'b0;
    press_pend[3] = 1'b1; press_pend[5] = 1'b1;
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", io.ev_valid, 1);
      chk("bp_key", io.ev_key, 3);
      chk("bp_en", io.pin_out_en, 4'b0010);
      @(negedge clk);
    end
    @(posedge clk); #1 io.ev_ready = 1'b1;
    @(negedge clk);
    chk("bb_first", io.ev_key, 3);
    @(negedge clk);
    chk("bb_second_valid", io.ev_valid, 1);
    chk("bb_second_key", io.ev_key, 5);
    chk("bb_second_pol", io.ev_pressed, 1);

    // Random press patterns, backpressure and enable toggling.
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      io.ev_ready = ($urandom_range(0, 3) != 0);
      io.enable   = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 40) == 0) press_pend = KC'($urandom) & KC'($urandom);
    end
    @(posedge clk); #1 io.enable = 1'b1; io.ev_ready = 1'b1;
    wait_scans(3);

    // Reset while an event is pending.
    press_pend = ~m_keys;
    @(posedge clk); #1 io.ev_ready = 1'b0;
    wait_valid();
    @(posedge clk); #2 rst = 1'b1;
    #1;
    chk("arst_valid", io.ev_valid, 0);
    chk("arst_keys", io.keys, 0);
    chk("arst_en", io.pin_out_en, 0);
    chk("arst_key", io.ev_key, 0);
    @(posedge clk); #1 rst = 1'b0; io.ev_ready = 1'b1;
    a0 = n_acc;
    @(negedge clk);
    wait_en(4'b0001);
    chk("restart_pin", io.pin_out_en, 4'b0001);
    wait_scans(1);
    chk("first_scan_no_ev", n_acc - a0, 0);
    wait_scans(2);

    chk("onehot", bad_onehot, 0);
    chk("pin_value", bad_val, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
